// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  // Instruction field bit positions
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise the
// entry is consumed and valid drops.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc4
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      instr <= NOP_WORD;
      pc4   <= 32'h0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc4   <= pc4_in;
    end else if (!hold) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding-request instruction fetch stage feeding an IF/ID register.
// Optional macro FETCH_COUNT_EN adds fetch/squash event counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [4:0]  read0,
  output logic [4:0]  read1,
  output logic [4:0]  write,
  output logic [15:0] imm
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
`endif
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  hold_reg;
  logic         squash_reg;

  logic         ifid_load;
  logic         drop;
  logic [31:0]  ifid_src;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_reg + 32'd4;

  always_comb begin
    ifid_load = 1'b0;
    drop      = 1'b0;
    ifid_src  = imem_rdata;
    case (state_reg)
      ST_WAIT: begin
        if (imem_valid) begin
          if (branch_taken || squash_reg) drop = 1'b1;
          else if (!id_valid || !stall)   ifid_load = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!branch_taken && !stall) begin
          ifid_load = 1'b1;
          ifid_src  = hold_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_ISSUE;
      pc_reg     <= RESET_PC;
      hold_reg   <= NOP_WORD;
      squash_reg <= 1'b0;
    end else begin
      if (branch_taken) begin
        pc_reg   <= align_word(branch_target);
        hold_reg <= NOP_WORD;
      end else if (ifid_load) begin
        pc_reg <= pc_plus4;
      end
      case (state_reg)
        ST_ISSUE: state_reg <= branch_taken ? ST_ISSUE : ST_WAIT;
        ST_WAIT: begin
          if (imem_valid) begin
            squash_reg <= 1'b0;
            if (drop || ifid_load) begin
              state_reg <= ST_ISSUE;
            end else begin
              hold_reg  <= imem_rdata;
              state_reg <= ST_HOLD;
            end
          end else if (branch_taken) begin
            // Outstanding response belongs to the old path; drop it when it lands.
            squash_reg <= 1'b1;
          end
        end
        ST_HOLD: if (branch_taken || !stall) state_reg <= ST_ISSUE;
        default: state_reg <= ST_ISSUE;
      endcase
    end
  end

  ifid_reg u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (ifid_load),
    .flush    (branch_taken),
    .hold     (stall),
    .instr_in (ifid_src),
    .pc4_in   (pc_plus4),
    .valid    (id_valid),
    .instr    (id_instr),
    .pc4      (id_pc4)
  );

  // Request is masked during reset so nothing leaves before rst rises.
  assign imem_req  = rst && (state_reg == ST_ISSUE) && !branch_taken;
  assign imem_addr = pc_reg;
  assign read0     = id_instr[RS_MSB:RS_LSB];
  assign read1     = id_instr[RT_MSB:RT_LSB];
  assign write     = id_instr[RD_MSB:RD_LSB];
  assign imm       = id_instr[IMM_MSB:IMM_LSB];

`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] squash_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_reg  <= 32'h0;
      squash_cnt_reg <= 32'h0;
    end else begin
      if (ifid_load) fetch_cnt_reg  <= fetch_cnt_reg + 32'd1;
      if (drop)      squash_cnt_reg <= squash_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_reg;
  assign squash_cnt = squash_cnt_reg;
`endif

endmodule
